// File: rtl/axi_tlb_lookup.sv
// Shared AW/AR translation lookup: one comparator bank, round-robin
// arbitration, and a registered hit/address result slot per side.
module axi_tlb_lookup #(
  parameter int unsigned InpAddrWidth = 32,
  parameter int unsigned OupAddrWidth = 32,
  parameter int unsigned NumEntries   = 4,
  parameter int unsigned PageWidth    = 12,
  localparam int unsigned IPW = InpAddrWidth - PageWidth,
  localparam int unsigned OPW = OupAddrWidth - PageWidth,
  localparam int unsigned EW  = 2 + 2 * IPW + OPW
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [InpAddrWidth-1:0]    wr_req_addr_i,
  input  logic                       wr_req_valid_i,
  output logic                       wr_req_ready_o,
  output logic                       wr_res_hit_o,
  output logic [OupAddrWidth-1:0]    wr_res_addr_o,
  output logic                       wr_res_valid_o,
  input  logic                       wr_res_ready_i,
  input  logic [InpAddrWidth-1:0]    rd_req_addr_i,
  input  logic                       rd_req_valid_i,
  output logic                       rd_req_ready_o,
  output logic                       rd_res_hit_o,
  output logic [OupAddrWidth-1:0]    rd_res_addr_o,
  output logic                       rd_res_valid_o,
  input  logic                       rd_res_ready_i,
  input  logic [NumEntries*EW-1:0]   entries_i
);

  typedef struct packed {
    logic           valid;
    logic           read_only;
    logic [IPW-1:0] first;
    logic [IPW-1:0] last;
    logic [OPW-1:0] base;
  } entry_t;

  typedef enum logic {
    RR_WR = 1'b0,
    RR_RD = 1'b1
  } rr_e;

  rr_e                     r_rr;
  logic                    r_wr_valid;
  logic                    r_wr_hit;
  logic [OupAddrWidth-1:0] r_wr_addr;
  logic                    r_rd_valid;
  logic                    r_rd_hit;
  logic [OupAddrWidth-1:0] r_rd_addr;

  entry_t                  w_ent   [NumEntries];
  logic                    w_match [NumEntries];
  logic [IPW-1:0]          w_diff  [NumEntries];
  logic [OPW-1:0]          w_xlat  [NumEntries];

  logic                    w_wr_elig;
  logic                    w_rd_elig;
  logic                    w_gnt_wr;
  logic                    w_gnt_rd;
  logic [InpAddrWidth-1:0] w_lk_addr;
  logic                    w_lk_wr;
  logic [IPW-1:0]          w_page;
  logic                    w_hit;
  logic [OupAddrWidth-1:0] w_out;

  // A slot is free when empty or being drained this very cycle.
  always_comb begin
    w_wr_elig = !rst_i && wr_req_valid_i
                && (!r_wr_valid || wr_res_ready_i);
    w_rd_elig = !rst_i && rd_req_valid_i
                && (!r_rd_valid || rd_res_ready_i);
    w_gnt_wr  = w_wr_elig && (!w_rd_elig || r_rr == RR_WR);
    w_gnt_rd  = w_rd_elig && (!w_wr_elig || r_rr == RR_RD);
  end

  assign wr_req_ready_o = w_gnt_wr;
  assign rd_req_ready_o = w_gnt_rd;

  always_comb begin
    w_lk_addr = w_gnt_rd ? rd_req_addr_i : wr_req_addr_i;
    w_lk_wr   = !w_gnt_rd;
    w_page    = w_lk_addr[InpAddrWidth-1:PageWidth];
  end

  always_comb begin
    for (int i = 0; i < int'(NumEntries); i++) begin
      w_ent[i]   = entry_t'(entries_i[i*EW +: EW]);
      w_match[i] = w_ent[i].valid
                   && (w_page >= w_ent[i].first)
                   && (w_page <= w_ent[i].last)
                   && !(w_lk_wr && w_ent[i].read_only);
      w_diff[i]  = w_page - w_ent[i].first;
      w_xlat[i]  = w_ent[i].base + OPW'(w_diff[i]);
    end
  end

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    w_hit = 1'b0;
    w_out = '0;
    for (int i = int'(NumEntries) - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_out = {w_xlat[i], w_lk_addr[PageWidth-1:0]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr       <= RR_WR;
      r_wr_valid <= 1'b0;
      r_wr_hit   <= 1'b0;
      r_wr_addr  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
      r_rd_addr  <= '0;
    end else begin
      if (w_wr_elig && w_rd_elig) begin
        r_rr <= (r_rr == RR_WR) ? RR_RD : RR_WR;
      end
      if (w_gnt_wr) begin
        r_wr_valid <= 1'b1;
        r_wr_hit   <= w_hit;
        r_wr_addr  <= w_out;
      end else if (wr_res_ready_i) begin
        r_wr_valid <= 1'b0;
      end
      if (w_gnt_rd) begin
        r_rd_valid <= 1'b1;
        r_rd_hit   <= w_hit;
        r_rd_addr  <= w_out;
      end else if (rd_res_ready_i) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign wr_res_valid_o = r_wr_valid;
  assign wr_res_hit_o   = r_wr_hit;
  assign wr_res_addr_o  = r_wr_addr;
  assign rd_res_valid_o = r_rd_valid;
  assign rd_res_hit_o   = r_rd_hit;
  assign rd_res_addr_o  = r_rd_addr;

endmodule

// File: tb/tb_axi_tlb_lookup.sv
// Directed bench for axi_tlb_lookup: vector table plus
// round-robin, backpressure and reset sequences.
module tb_axi_tlb_lookup;

  localparam int unsigned IAW = 24;
  localparam int unsigned OAW = 24;
  localparam int unsigned NE  = 2;
  localparam int unsigned PW  = 12;
  localparam int unsigned IPW = IAW - PW;
  localparam int unsigned OPW = OAW - PW;
  localparam int unsigned EW  = 2 + 2 * IPW + OPW;

  typedef struct packed {
    logic           valid;
    logic           read_only;
    logic [IPW-1:0] first;
    logic [IPW-1:0] last;
    logic [OPW-1:0] base;
  } ent_t;

  typedef struct {
    logic            rd;
    logic [IAW-1:0]  addr;
    ent_t            e0;
    ent_t            e1;
    logic            hit;
    logic [OAW-1:0]  res;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [IAW-1:0] wr_req_addr, rd_req_addr;
  logic           wr_req_valid, rd_req_valid;
  logic           wr_req_ready, rd_req_ready;
  logic           wr_res_hit, rd_res_hit;
  logic [OAW-1:0] wr_res_addr, rd_res_addr;
  logic           wr_res_valid, rd_res_valid;
  logic           wr_res_ready, rd_res_ready;
  logic [NE*EW-1:0] entries;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_tlb_lookup #(
    .InpAddrWidth(IAW),
    .OupAddrWidth(OAW),
    .NumEntries  (NE),
    .PageWidth   (PW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_req_addr_i (wr_req_addr),
    .wr_req_valid_i(wr_req_valid),
    .wr_req_ready_o(wr_req_ready),
    .wr_res_hit_o  (wr_res_hit),
    .wr_res_addr_o (wr_res_addr),
    .wr_res_valid_o(wr_res_valid),
    .wr_res_ready_i(wr_res_ready),
    .rd_req_addr_i (rd_req_addr),
    .rd_req_valid_i(rd_req_valid),
    .rd_req_ready_o(rd_req_ready),
    .rd_res_hit_o  (rd_res_hit),
    .rd_res_addr_o (rd_res_addr),
    .rd_res_valid_o(rd_res_valid),
    .rd_res_ready_i(rd_res_ready),
    .entries_i     (entries)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic v, input logic ro,
                              input int f, input int l, input int b);
    ent_t e;
    e.valid     = v;
    e.read_only = ro;
    e.first     = IPW'(f);
    e.last      = IPW'(l);
    e.base      = OPW'(b);
    return e;
  endfunction

  // Inputs change #1 after the rising edge; checks happen on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];
  ent_t e_basic, e_ro, e_pri0, e_pri1, e_off, e_wrap, e_none;
  logic [OAW-1:0] held;

  initial begin
    e_basic = mk(1, 0, 'h10, 'h1F, 'h80);
    e_ro    = mk(1, 1, 'h10, 'h1F, 'h80);
    e_pri0  = mk(1, 0, 'h20, 'h20, 'h40);
    e_pri1  = mk(1, 0, 'h00, 'hFF, 'h100);
    e_off   = mk(0, 0, 'h10, 'h1F, 'h80);
    e_wrap  = mk(1, 0, 'h000, 'hFFF, 'hFFF);
    e_none  = mk(0, 0, 0, 0, 0);

    vecs[0]  = '{1, 24'h015ABC, e_basic, e_none, 1, 24'h085ABC};
    vecs[1]  = '{0, 24'h012000, e_ro,    e_none, 0, 24'h000000};
    vecs[2]  = '{1, 24'h012000, e_ro,    e_none, 1, 24'h082000};
    vecs[3]  = '{1, 24'h020004, e_pri0,  e_pri1, 1, 24'h040004};
    vecs[4]  = '{0, 24'h021004, e_pri0,  e_pri1, 1, 24'h121004};
    vecs[5]  = '{1, 24'h100000, e_pri0,  e_pri1, 0, 24'h000000};
    vecs[6]  = '{0, 24'h01F000, e_basic, e_none, 1, 24'h08F000};
    vecs[7]  = '{1, 24'h010000, e_basic, e_none, 1, 24'h080000};
    vecs[8]  = '{1, 24'h020000, e_basic, e_none, 0, 24'h000000};
    vecs[9]  = '{1, 24'h015ABC, e_off,   e_none, 0, 24'h000000};
    vecs[10] = '{0, 24'h002345, e_wrap,  e_none, 1, 24'h001345};

    rst = 1'b1;
    wr_req_addr = '0; rd_req_addr = '0;
    wr_req_valid = 1'b1; rd_req_valid = 1'b1;
    wr_res_ready = 1'b1; rd_res_ready = 1'b1;
    entries = {e_none, e_basic};
    step(); step();
    @(negedge clk);
    chk("rst wr_valid", 32'(wr_res_valid), 0);
    chk("rst rd_valid", 32'(rd_res_valid), 0);
    chk("rst wr_hit", 32'(wr_res_hit), 0);
    chk("rst rd_hit", 32'(rd_res_hit), 0);
    chk("rst wr_addr", 32'(wr_res_addr), 0);
    chk("rst rd_addr", 32'(rd_res_addr), 0);
    chk("rst wr_ready", 32'(wr_req_ready), 0);
    chk("rst rd_ready", 32'(rd_req_ready), 0);
    step();
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    rst = 1'b0;
    step();

    foreach (vecs[k]) begin
      entries = {vecs[k].e1, vecs[k].e0};
      if (vecs[k].rd) begin
        rd_req_addr = vecs[k].addr; rd_req_valid = 1'b1;
      end else begin
        wr_req_addr = vecs[k].addr; wr_req_valid = 1'b1;
      end
      @(negedge clk);
      chk($sformatf("v%0d req_ready", k),
          32'(vecs[k].rd ? rd_req_ready : wr_req_ready), 1);
      step();
      wr_req_valid = 1'b0; rd_req_valid = 1'b0;
      entries = {e_none, e_none};
      @(negedge clk);
      chk($sformatf("v%0d res_valid", k),
          32'(vecs[k].rd ? rd_res_valid : wr_res_valid), 1);
      chk($sformatf("v%0d hit", k),
          32'(vecs[k].rd ? rd_res_hit : wr_res_hit), 32'(vecs[k].hit));
      chk($sformatf("v%0d addr", k),
          32'(vecs[k].rd ? rd_res_addr : wr_res_addr), 32'(vecs[k].res));
      step();
    end

    // Backpressure: fill write slot, hold it, read side runs freely.
    entries = {e_none, e_basic};
    wr_res_ready = 1'b0;
    wr_req_addr = 24'h011111; wr_req_valid = 1'b1;
    step();
    wr_req_addr = 24'h01E222;
    rd_req_addr = 24'h013333; rd_req_valid = 1'b1;
    entries = {e_none, e_ro};
    held = 24'h081111;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d wr_ready", c), 32'(wr_req_ready), 0);
      chk($sformatf("bp%0d rd_ready", c), 32'(rd_req_ready), 1);
      chk($sformatf("bp%0d wr_valid", c), 32'(wr_res_valid), 1);
      chk($sformatf("bp%0d wr_addr", c), 32'(wr_res_addr), 32'(held));
      if (c > 0) begin
        chk($sformatf("bp%0d rd_addr", c), 32'(rd_res_addr), 32'h083333);
      end
      step();
    end
    rd_req_valid = 1'b0;
    entries = {e_none, e_basic};
    wr_res_ready = 1'b1;
    @(negedge clk);
    chk("bp refill wr_ready", 32'(wr_req_ready), 1);
    chk("bp refill wr_valid", 32'(wr_res_valid), 1);
    step();
    wr_req_valid = 1'b0;
    @(negedge clk);
    chk("bp new wr_valid", 32'(wr_res_valid), 1);
    chk("bp new wr_addr", 32'(wr_res_addr), 32'h08E222);
    step(); step();

    // Fill both slots, then reset mid-flight.
    wr_res_ready = 1'b0; rd_res_ready = 1'b0;
    wr_req_valid = 1'b1; rd_req_valid = 1'b1;
    wr_req_addr = 24'h012000; rd_req_addr = 24'h014000;
    step(); step();
    @(negedge clk);
    chk("full wr_valid", 32'(wr_res_valid), 1);
    chk("full rd_valid", 32'(rd_res_valid), 1);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("midrst wr_valid", 32'(wr_res_valid), 0);
    chk("midrst rd_valid", 32'(rd_res_valid), 0);
    chk("midrst wr_ready", 32'(wr_req_ready), 0);
    step();
    rst = 1'b0;
    wr_res_ready = 1'b1; rd_res_ready = 1'b1;

    // Round-robin after reset: W, R, W, R.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rr%0d wr_ready", c), 32'(wr_req_ready),
          32'(c % 2 == 0));
      chk($sformatf("rr%0d rd_ready", c), 32'(rd_req_ready),
          32'(c % 2 == 1));
      if (c > 0) begin
        chk($sformatf("rr%0d wr_valid", c), 32'(wr_res_valid),
            32'(c % 2 == 1));
        chk($sformatf("rr%0d rd_valid", c), 32'(rd_res_valid),
            32'(c % 2 == 0));
      end
      step();
    end
    wr_req_valid = 1'b0; rd_req_valid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
